i2c_passthru_byte_seq: RTL and testbench

I2C_PASSTHRU_BYTE_SEQ -- requirements
Module: i2c_passthru_byte_seq

---
 rtl/i2c_passthru_byte_seq_if.sv | 36 +++
 rtl/i2c_passthru_byte_seq.sv | 145 ++++++++++++++
 tb/tb_i2c_passthru_byte_seq.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_passthru_byte_seq_if.sv
// Bundles the byte sequencer's bit-level handshake signals with the controller.
// The slave side belongs to the sequencer and the master side to whatever drives it.
interface i2c_passthru_byte_seq_if;
  logic       i_f_ref;
  logic       i_byte_start;
  logic       i_byte_is_read;
  logic       i_rx_done;
  logic       i_rx_sda_final;
  logic       i_tx_done;
  logic       i_tx_violation;
  logic       i_stop;
  logic       i_clear;
  logic       o_start_tx;
  logic       o_tx_is_to_mst;
  logic       o_busy;
  logic [3:0] o_bit_cnt;
  logic       o_byte_done;
  logic [7:0] o_byte;
  logic       o_nack;
  logic       o_abort;
  logic       o_timeout;

  modport slave (
    input  i_f_ref, i_byte_start, i_byte_is_read, i_rx_done, i_rx_sda_final,
           i_tx_done, i_tx_violation, i_stop, i_clear,
    output o_start_tx, o_tx_is_to_mst, o_busy, o_bit_cnt, o_byte_done,
           o_byte, o_nack, o_abort, o_timeout
  );

  modport master (
    output i_f_ref, i_byte_start, i_byte_is_read, i_rx_done, i_rx_sda_final,
           i_tx_done, i_tx_violation, i_stop, i_clear,
    input  o_start_tx, o_tx_is_to_mst, o_busy, o_bit_cnt, o_byte_done,
           o_byte, o_nack, o_abort, o_timeout
  );
endinterface

// File: rtl/i2c_passthru_byte_seq.sv
// Sequences one I2C byte (8 data bits + ACK slot) between a bit receiver and a
// bit transmitter, with an f_ref-based watchdog on every wait state.
module i2c_passthru_byte_seq #(
  parameter int unsigned F_REF_TIMEOUT       = 255,
  parameter int unsigned WIDTH_F_REF_TIMEOUT = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  i2c_passthru_byte_seq_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RX,
    ST_TX_REQ,
    ST_TX_WAIT,
    ST_DONE,
    ST_ABORT
  } state_e;

  localparam logic [WIDTH_F_REF_TIMEOUT-1:0] TIMER_RELOAD =
    WIDTH_F_REF_TIMEOUT'(F_REF_TIMEOUT);
  localparam logic [3:0] LAST_BIT = 4'd8;

  state_e                         state_q,   state_d;
  logic [WIDTH_F_REF_TIMEOUT-1:0] timer_q,   timer_d;
  logic [3:0]                     bit_cnt_q, bit_cnt_d;
  logic                           read_q,    read_d;
  logic [7:0]                     byte_q,    byte_d;
  logic                           nack_q,    nack_d;
  logic                           timeout_q, timeout_d;
  logic                           f_ref_prev_q;
  logic                           f_ref_rise;
  logic                           in_wait;

  assign f_ref_rise = bus.i_f_ref & ~f_ref_prev_q;
  assign in_wait    = (state_q == ST_WAIT_RX) || (state_q == ST_TX_REQ) ||
                      (state_q == ST_TX_WAIT);

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    read_d    = read_q;
    byte_d    = byte_q;
    nack_d    = nack_q;
    timeout_d = timeout_q;

    if (bus.i_clear) timeout_d = 1'b0;
    if (in_wait && f_ref_rise && (timer_q != '0)) timer_d = timer_q - 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_byte_start) begin
          read_d    = bus.i_byte_is_read;
          bit_cnt_d = '0;
          byte_d    = '0;
          nack_d    = 1'b0;
          timer_d   = TIMER_RELOAD;
          state_d   = ST_WAIT_RX;
        end
      end
      ST_WAIT_RX, ST_TX_REQ, ST_TX_WAIT: begin
        // Violation beats timeout beats stop beats the normal handshake.
        if (bus.i_tx_violation) begin
          state_d = ST_ABORT;
        end else if (timer_q == '0) begin
          state_d   = ST_ABORT;
          timeout_d = 1'b1;
        end else if (bus.i_stop) begin
          state_d = ST_IDLE;
        end else begin
          unique case (state_q)
            ST_WAIT_RX: begin
              if (bus.i_rx_done) begin
                if (bit_cnt_q == LAST_BIT) nack_d = bus.i_rx_sda_final;
                else                       byte_d = {byte_q[6:0], bus.i_rx_sda_final};
                state_d = ST_TX_REQ;
              end
            end
            ST_TX_REQ: begin
              if (!bus.i_tx_done) begin
                timer_d = TIMER_RELOAD;
                state_d = ST_TX_WAIT;
              end
            end
            default: begin
              if (bus.i_tx_done) begin
                if (bit_cnt_q == LAST_BIT) begin
                  state_d = ST_DONE;
                end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  timer_d   = TIMER_RELOAD;
                  state_d   = ST_WAIT_RX;
                end
              end
            end
          endcase
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: if (bus.i_clear) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q   <= ST_IDLE;
      timer_q   <= TIMER_RELOAD;
      bit_cnt_q <= '0;
      read_q    <= 1'b0;
      byte_q    <= '0;
      nack_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all update together at the edge.
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      read_q    <= read_d;
      byte_q    <= byte_d;
      nack_q    <= nack_d;
      timeout_q <= timeout_d;
    end
  end

  // NOTE: no reset here; at worst one spurious f_ref edge is seen right after reset.
  always_ff @(posedge i_clk) begin
    f_ref_prev_q <= bus.i_f_ref;
  end

  assign bus.o_start_tx     = (state_q == ST_TX_REQ) ||
                              ((state_q == ST_TX_WAIT) && !bus.i_tx_done);
  assign bus.o_tx_is_to_mst = (bit_cnt_q == LAST_BIT) ? ~read_q : read_q;
  assign bus.o_busy         = (state_q != ST_IDLE);
  assign bus.o_bit_cnt      = bit_cnt_q;
  assign bus.o_byte_done    = (state_q == ST_DONE);
  assign bus.o_byte         = byte_q;
  assign bus.o_nack         = nack_q;
  assign bus.o_abort        = (state_q == ST_ABORT);
  assign bus.o_timeout      = timeout_q;

endmodule

// File: tb/tb_i2c_passthru_byte_seq.sv
// Directed bench for the byte sequencer: full write/read bytes, abort paths,
// stop handling, mid-byte reset and watchdog timeout with a short timer.
module tb_i2c_passthru_byte_seq;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;

  i2c_passthru_byte_seq_if bus ();

  i2c_passthru_byte_seq #(
    .F_REF_TIMEOUT       (4),
    .WIDTH_F_REF_TIMEOUT (3)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.o_byte_done === 1'b1) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_byte(input logic rd);
    bus.i_byte_start   = 1'b1;
    bus.i_byte_is_read = rd;
    step();
    bus.i_byte_start   = 1'b0;
  endtask

  // One full bit: rx capture, transmitter goes busy, transmitter returns idle.
  task automatic do_bit(input string tag, input logic sda, input logic exp_dir);
    check({tag, "_dir_rx"}, 32'(bus.o_tx_is_to_mst), 32'(exp_dir));
    bus.i_rx_done      = 1'b1;
    bus.i_rx_sda_final = sda;
    step();
    bus.i_rx_done      = 1'b0;
    check({tag, "_start_req"}, 32'(bus.o_start_tx), 32'd1);
    bus.i_tx_done = 1'b0;
    step();
    check({tag, "_start_wait"}, 32'(bus.o_start_tx), 32'd1);
    check({tag, "_dir_tx"}, 32'(bus.o_tx_is_to_mst), 32'(exp_dir));
    bus.i_tx_done = 1'b1;
    step();
    check({tag, "_start_off"}, 32'(bus.o_start_tx), 32'd0);
  endtask

  // seq[8] is the first bit on the wire (data MSB), seq[0] the ACK slot.
  task automatic run_bits(input string tag, input logic rd, input logic [8:0] seq,
                          input int first, input int last);
    for (int i = first; i <= last; i++)
      do_bit($sformatf("%s_b%0d", tag, i), seq[8-i], (i < 8) ? rd : ~rd);
  endtask

  initial begin
    int done_ref;
    logic [8:0] seq;

    rst_n              = 1'b0;
    bus.i_f_ref        = 1'b0;
    bus.i_byte_start   = 1'b0;
    bus.i_byte_is_read = 1'b0;
    bus.i_rx_done      = 1'b0;
    bus.i_rx_sda_final = 1'b0;
    bus.i_tx_done      = 1'b1;
    bus.i_tx_violation = 1'b0;
    bus.i_stop         = 1'b0;
    bus.i_clear        = 1'b0;
    step();
    step();
    check("rst_busy",    32'(bus.o_busy),      32'd0);
    check("rst_start",   32'(bus.o_start_tx),  32'd0);
    check("rst_bitcnt",  32'(bus.o_bit_cnt),   32'd0);
    check("rst_byte",    32'(bus.o_byte),      32'h00);
    check("rst_nack",    32'(bus.o_nack),      32'd0);
    check("rst_abort",   32'(bus.o_abort),     32'd0);
    check("rst_timeout", 32'(bus.o_timeout),   32'd0);
    rst_n = 1'b1;
    step();

    // Write 0xA5 with ACK.
    seq = {8'hA5, 1'b0};
    start_byte(1'b0);
    check("wr_busy",   32'(bus.o_busy),    32'd1);
    check("wr_bitcnt", 32'(bus.o_bit_cnt), 32'd0);
    run_bits("wr", 1'b0, seq, 0, 8);
    check("wr_done",      32'(bus.o_byte_done), 32'd1);
    check("wr_byte",      32'(bus.o_byte),      32'hA5);
    check("wr_nack",      32'(bus.o_nack),      32'd0);
    step();
    check("wr_done_off",  32'(bus.o_byte_done), 32'd0);
    check("wr_idle",      32'(bus.o_busy),      32'd0);
    check("wr_byte_hold", 32'(bus.o_byte),      32'hA5);
    check("wr_done_cnt",  32'(done_cnt),        32'd1);

    // Read 0x3C with NACK.
    seq = {8'h3C, 1'b1};
    start_byte(1'b1);
    run_bits("rd", 1'b1, seq, 0, 8);
    check("rd_done", 32'(bus.o_byte_done), 32'd1);
    check("rd_byte", 32'(bus.o_byte),      32'h3C);
    check("rd_nack", 32'(bus.o_nack),      32'd1);
    step();
    check("rd_done_cnt", 32'(done_cnt), 32'd2);

    // Transmitter violation while waiting on bit 3.
    done_ref = done_cnt;
    seq = {8'hFF, 1'b0};
    start_byte(1'b0);
    run_bits("vio", 1'b0, seq, 0, 2);
    bus.i_rx_done = 1'b1; bus.i_rx_sda_final = 1'b1;
    step();
    bus.i_rx_done = 1'b0; bus.i_tx_done = 1'b0;
    step();
    check("vio_bitcnt", 32'(bus.o_bit_cnt), 32'd3);
    bus.i_tx_violation = 1'b1;
    step();
    bus.i_tx_violation = 1'b0;
    bus.i_tx_done      = 1'b1;
    check("vio_abort",   32'(bus.o_abort),    32'd1);
    check("vio_start",   32'(bus.o_start_tx), 32'd0);
    check("vio_timeout", 32'(bus.o_timeout),  32'd0);
    check("vio_nodone",  32'(done_cnt),       32'(done_ref));
    step();
    check("vio_abort_hold", 32'(bus.o_abort), 32'd1);
    bus.i_clear = 1'b1;
    step();
    bus.i_clear = 1'b0;
    check("vio_clear_abort", 32'(bus.o_abort), 32'd0);
    check("vio_clear_busy",  32'(bus.o_busy),  32'd0);

    // Stop and violation together: violation wins.
    start_byte(1'b0);
    bus.i_stop = 1'b1; bus.i_tx_violation = 1'b1;
    step();
    bus.i_stop = 1'b0; bus.i_tx_violation = 1'b0;
    check("stopvio_abort", 32'(bus.o_abort), 32'd1);
    bus.i_clear = 1'b1;
    step();
    bus.i_clear = 1'b0;
    check("stopvio_idle", 32'(bus.o_busy), 32'd0);

    // Stop alone at bit 5.
    done_ref = done_cnt;
    seq = {8'h96, 1'b0};
    start_byte(1'b0);
    run_bits("stp", 1'b0, seq, 0, 4);
    check("stp_bitcnt", 32'(bus.o_bit_cnt), 32'd5);
    bus.i_stop = 1'b1;
    step();
    bus.i_stop = 1'b0;
    check("stp_idle",   32'(bus.o_busy),  32'd0);
    check("stp_abort",  32'(bus.o_abort), 32'd0);
    check("stp_nodone", 32'(done_cnt),    32'(done_ref));
    start_byte(1'b0);
    check("stp_restart_bitcnt", 32'(bus.o_bit_cnt), 32'd0);
    check("stp_restart_busy",   32'(bus.o_busy),     32'd1);
    bus.i_stop = 1'b1;
    step();
    bus.i_stop = 1'b0;

    // tx_done rise and stop together on the ACK bit: no completion pulse.
    done_ref = done_cnt;
    seq = {8'hC3, 1'b0};
    start_byte(1'b0);
    run_bits("ackstp", 1'b0, seq, 0, 7);
    bus.i_rx_done = 1'b1; bus.i_rx_sda_final = 1'b0;
    step();
    bus.i_rx_done = 1'b0; bus.i_tx_done = 1'b0;
    step();
    bus.i_tx_done = 1'b1; bus.i_stop = 1'b1;
    step();
    bus.i_stop = 1'b0;
    check("ackstp_idle",   32'(bus.o_busy), 32'd0);
    check("ackstp_nodone", 32'(done_cnt),   32'(done_ref));
    check("ackstp_byte",   32'(bus.o_byte), 32'hC3);

    // Reset in the middle of bit 6.
    seq = {8'hFF, 1'b1};
    start_byte(1'b1);
    run_bits("mrst", 1'b1, seq, 0, 5);
    bus.i_rx_done = 1'b1; bus.i_rx_sda_final = 1'b1;
    step();
    bus.i_rx_done = 1'b0; bus.i_tx_done = 1'b0;
    step();
    check("mrst_pre_start", 32'(bus.o_start_tx), 32'd1);
    rst_n = 1'b0;
    step();
    check("mrst_start",  32'(bus.o_start_tx),  32'd0);
    check("mrst_busy",   32'(bus.o_busy),      32'd0);
    check("mrst_bitcnt", 32'(bus.o_bit_cnt),   32'd0);
    check("mrst_byte",   32'(bus.o_byte),      32'h00);
    check("mrst_nack",   32'(bus.o_nack),      32'd0);
    check("mrst_abort",  32'(bus.o_abort),     32'd0);
    check("mrst_done",   32'(bus.o_byte_done), 32'd0);
    rst_n = 1'b1;
    bus.i_tx_done = 1'b1;
    step();

    // byte_start while busy is ignored: direction and count carry on.
    seq = {8'h5A, 1'b0};
    start_byte(1'b0);
    run_bits("busy", 1'b0, seq, 0, 1);
    start_byte(1'b1);
    check("busy_bitcnt", 32'(bus.o_bit_cnt), 32'd2);
    run_bits("busy", 1'b0, seq, 2, 8);
    check("busy_done", 32'(bus.o_byte_done), 32'd1);
    check("busy_byte", 32'(bus.o_byte),      32'h5A);
    check("busy_nack", 32'(bus.o_nack),      32'd0);
    step();

    // Watchdog: four f_ref rising edges with no rx_done.
    start_byte(1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.i_f_ref = 1'b1; step();
      bus.i_f_ref = 1'b0; step();
    end
    check("to_not_yet", 32'(bus.o_abort), 32'd0);
    bus.i_f_ref = 1'b1; step();
    bus.i_f_ref = 1'b0; step();
    check("to_abort",   32'(bus.o_abort),    32'd1);
    check("to_timeout", 32'(bus.o_timeout),  32'd1);
    check("to_start",   32'(bus.o_start_tx), 32'd0);
    bus.i_clear = 1'b1;
    step();
    bus.i_clear = 1'b0;
    check("to_clear_timeout", 32'(bus.o_timeout), 32'd0);
    check("to_clear_busy",    32'(bus.o_busy),    32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
